score_tracker: RTL and testbench

Parametrised BCD score/high-score tracker for the runner game: counts points from frame ticks while a run is active, freezes on collision, and latches a high score. It sits between the frame-tick generator and collision detector on the input side and the seven-segment/VGA score display on the output side.

---
 rtl/score_tracker.sv | 100 ++++++++++
 tb/tb_score_tracker.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/score_tracker.sv
// BCD score and high-score tracker for the runner game.
// Scores frame ticks while running, freezes on collision, latches the best run.
module score_tracker #(
   parameter int DIGITS          = 4,
   parameter int TICKS_PER_POINT = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  tick,
   input  logic                  hit,
   output logic [4*DIGITS-1:0]   score,
   output logic [4*DIGITS-1:0]   high_score,
   output logic [1:0]            state,
   output logic                  new_high
);

   localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_POINT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_OVER = 2'b10,
      ST_BAD  = 2'b11
   } state_e;

   state_e                state_q;
   logic [PW-1:0]         ps_q;
   logic [4*DIGITS-1:0]   score_q;
   logic [4*DIGITS-1:0]   high_q;
   logic                  new_high_q;

   logic [4*DIGITS-1:0]   score_inc;
   logic [4*DIGITS-1:0]   score_d;
   logic                  carry;

   // Ripple a +1 through the digits; a carry out means all nines, so hold.
   always_comb begin
      score_inc = score_q;
      carry     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (score_q[4*i +: 4] == 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      score_d = carry ? score_q : score_inc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ps_q       <= '0;
         score_q    <= '0;
         high_q     <= '0;
         new_high_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_OVER: begin
               if (start) begin
                  state_q    <= ST_RUN;
                  ps_q       <= '0;
                  score_q    <= '0;
                  new_high_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (hit) begin
                  state_q <= ST_OVER;
                  if (score_q > high_q) begin
                     high_q     <= score_q;
                     new_high_q <= 1'b1;
                  end else begin
                     new_high_q <= 1'b0;
                  end
               end else if (tick) begin
                  if (ps_q == PS_MAX) begin
                     ps_q    <= '0;
                     score_q <= score_d;
                  end else begin
                     ps_q <= ps_q + 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign score      = score_q;
   assign high_score = high_q;
   assign state      = state_q;
   assign new_high   = new_high_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed self-checking bench for score_tracker (DIGITS=4, TICKS_PER_POINT=6).
// Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
`timescale 1ns/1ps
module tb_score_tracker;

   logic        clk = 1'b0;
   logic        reset, start, tick, hit;
   logic [15:0] score, high_score;
   logic [1:0]  state;
   logic        new_high;

   int checks = 0;
   int errors = 0;

   score_tracker #(.DIGITS(4), .TICKS_PER_POINT(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .tick       (tick),
      .hit        (hit),
      .score      (score),
      .high_score (high_score),
      .state      (state),
      .new_high   (new_high)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic s, input logic t, input logic h);
      @(negedge clk);
      start = s;
      tick  = t;
      hit   = h;
      @(posedge clk);
      #1;
      start = 1'b0;
      tick  = 1'b0;
      hit   = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) cyc(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; tick = 1'b0; hit = 1'b0;
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_score", 32'(score), 32'h0);
      chk("rst_high", 32'(high_score), 32'h0);
      chk("rst_nh", 32'(new_high), 32'h0);
      reset = 1'b0;

      cyc(1'b0, 1'b1, 1'b1);
      chk("idle_hit_tick", 32'(state), 32'h0);

      cyc(1'b1, 1'b0, 1'b0);
      chk("start_state", 32'(state), 32'h1);
      chk("start_score", 32'(score), 32'h0);

      ticks(5);
      chk("tick5", 32'(score), 32'h0);
      ticks(1);
      chk("tick6", 32'(score), 32'h1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("run_start_ign", 32'(score), 32'h1);
      ticks(54);
      chk("tick60", 32'(score), 32'h10);
      ticks(32 * 6);
      chk("to42", 32'(score), 32'h42);

      cyc(1'b0, 1'b1, 1'b1);
      chk("hit_state", 32'(state), 32'h2);
      chk("hit_score", 32'(score), 32'h42);
      chk("hit_high", 32'(high_score), 32'h42);
      chk("hit_nh", 32'(new_high), 32'h1);
      ticks(6);
      cyc(1'b0, 1'b0, 1'b1);
      chk("over_frozen", 32'(score), 32'h42);
      chk("over_state", 32'(state), 32'h2);

      cyc(1'b1, 1'b0, 1'b0);
      chk("re_score", 32'(score), 32'h0);
      chk("re_high", 32'(high_score), 32'h42);
      chk("re_nh", 32'(new_high), 32'h0);
      ticks(42 * 6);
      cyc(1'b0, 1'b0, 1'b1);
      chk("eq_high", 32'(high_score), 32'h42);
      chk("eq_nh", 32'(new_high), 32'h0);

      cyc(1'b1, 1'b0, 1'b0);
      ticks(30 * 6);
      cyc(1'b0, 1'b0, 1'b1);
      chk("lo_score", 32'(score), 32'h30);
      chk("lo_high", 32'(high_score), 32'h42);
      chk("lo_nh", 32'(new_high), 32'h0);

      cyc(1'b1, 1'b0, 1'b0);
      ticks(99 * 6);
      chk("to99", 32'(score), 32'h99);
      ticks(6);
      chk("carry100", 32'(score), 32'h100);
      ticks(9899 * 6);
      chk("to9999", 32'(score), 32'h9999);
      ticks(12);
      chk("sat", 32'(score), 32'h9999);
      cyc(1'b0, 1'b0, 1'b1);
      chk("sat_high", 32'(high_score), 32'h9999);
      chk("sat_nh", 32'(new_high), 32'h1);

      cyc(1'b1, 1'b0, 1'b1);
      chk("start_hit_st", 32'(state), 32'h1);
      chk("start_hit_sc", 32'(score), 32'h0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("late_hit_st", 32'(state), 32'h2);
      chk("late_hit_nh", 32'(new_high), 32'h0);

      cyc(1'b1, 1'b0, 1'b0);
      ticks(17 * 6);
      chk("to17", 32'(score), 32'h17);
      reset = 1'b1;
      cyc(1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      chk("mid_rst_state", 32'(state), 32'h0);
      chk("mid_rst_score", 32'(score), 32'h0);
      chk("mid_rst_high", 32'(high_score), 32'h0);
      chk("mid_rst_nh", 32'(new_high), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
